l1_req_arbiter: RTL and testbench
=================================

L1_REQ_ARBITER -- requirements
Module: l1_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before a forced miss response.
REQ-002 Parameter CNT_W, default 10: width of each per-requester hit and miss counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0_valid / req1_valid  input  1  requester N has an address pending.
REQ-007 req0_addr / req1_addr  input  32  requester N byte address.
REQ-008 req0_ready / req1_ready  output  1  combinational grant; a handshake occurs when valid and ready are both high at a rising edge.
REQ-009 resp0_valid / resp1_valid  output  1  one-cycle response strobe to requester N.
REQ-010 resp_hit  output  1  hit result qualifying respN_valid.
REQ-011 cache_start  output  1  one-cycle lookup start to the L1 cache.
REQ-012 cache_addr  output  32  latched address presented to the cache.
REQ-013 cache_done  input  1  cache lookup complete.
REQ-014 cache_hit  input  1  found-in-cache flag, sampled with cache_done.
REQ-015 hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1  output  CNT_W  per-requester statistics.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 timeout_err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have four states, with these transitions:
- IDLE->ISSUE on a handshake.
- ISSUE->WAIT unconditionally.
- WAIT->RESP on cache_done or on timeout.
- RESP->IDLE unconditionally.
REQ-019 In IDLE, reqN_ready SHALL be high for exactly one requester, selected as follows:
- Only one valid: that requester.
- Both valid: the requester named by the priority pointer.
- Neither valid: both ready low.
REQ-020 Outside IDLE, both reqN_ready SHALL be low.
REQ-021 On handshake the block SHALL latch the address into cache_addr and record the owner; cache_addr SHALL hold until the next handshake.
REQ-022 cache_start SHALL be high only in ISSUE, i.e. exactly one cycle, on the cycle after the handshake.
REQ-023 cache_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-024 In WAIT, cache_done high at an edge SHALL capture cache_hit and move the FSM to RESP.
REQ-025 The WAIT cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES without cache_done, the block SHALL:
- force a captured hit of 0;
- set timeout_err;
- move to RESP.
REQ-026 In RESP, the block SHALL drive the following for one cycle:
- resp<owner>_valid = 1;
- resp_hit = captured hit.
REQ-027 The other requester's resp strobe SHALL stay low.
REQ-028 resp_hit SHALL be 0 outside RESP.
REQ-029 In RESP, exactly one counter SHALL increment: hit_cnt<owner> if the captured hit is 1, otherwise miss_cnt<owner>.
REQ-030 Each counter SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-031 In RESP, the priority pointer SHALL be set to the non-owner, giving round-robin service.
REQ-032 Minimum latency: handshake at edge k, cache_start in cycle k+1, and with cache_done at edge k+2, respN_valid in cycle k+2..k+3 (the RESP cycle).
REQ-033 Throughput SHALL be at most one request per 4 cycles.
REQ-034 A requester that deasserts valid before its handshake SHALL NOT be served.
REQ-035 Address changes after the handshake SHALL NOT affect cache_addr.
REQ-036 timeout_err SHALL clear only on reset.

Reset
REQ-037 While reset is low, asynchronously, the block SHALL force:
- state = IDLE;
- cache_start, all resp strobes, resp_hit, busy and timeout_err = 0;
- cache_addr = 0;
- priority pointer = 0;
- all counters = 0.
REQ-038 Reset asserted mid-transaction (ISSUE/WAIT/RESP) SHALL abort the transaction: no response and no counter update.
REQ-039 Ready SHALL be valid from the first rising edge after reset deasserts.

Verification
REQ-040 Single request: req0 addr 0x00000040, cache_done+hit=1 two cycles after start -> cache_start one cycle, resp0_valid one cycle with resp_hit=1, hit_cnt0=1, all other counters 0.
REQ-041 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; four responses give hit+miss totals of 2 per requester.
REQ-042 Timeout (TIMEOUT_CYCLES=64): cache_done never asserted -> resp valid 64 cycles after WAIT entry with resp_hit=0, miss count +1, timeout_err stays 1 across later transactions until reset.
REQ-043 Saturation (CNT_W=2): five hits on req1 -> hit_cnt1 reaches 3 and stays at 3.
REQ-044 Reset in WAIT: reset low for one cycle during WAIT, then stray cache_done -> no resp strobe, counters 0, busy 0, stray done ignored.
REQ-045 Stray cache_done in IDLE and cache_done coincident with cache_start -> ignored; FSM waits for done in WAIT.

Source files
------------

// File: rtl/l1_req_arbiter.sv
// Two-requester round-robin front end for the L1 cache: grants one lookup at a time,
// tracks a WAIT timeout, returns hit/miss to the owner and keeps saturating hit/miss stats.
module l1_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [31:0]      i_req0_addr,
    input  logic             i_req1_valid,
    input  logic [31:0]      i_req1_addr,
    output logic             o_req0_ready,
    output logic             o_req1_ready,
    output logic             o_resp0_valid,
    output logic             o_resp1_valid,
    output logic             o_resp_hit,
    output logic             o_cache_start,
    output logic [31:0]      o_cache_addr,
    input  logic             i_cache_done,
    input  logic             i_cache_hit,
    output logic [CNT_W-1:0] o_hit_cnt0,
    output logic [CNT_W-1:0] o_hit_cnt1,
    output logic [CNT_W-1:0] o_miss_cnt0,
    output logic [CNT_W-1:0] o_miss_cnt1,
    output logic             o_busy,
    output logic             o_timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic              r_prio;
    logic              r_owner;
    logic              r_hit;
    logic [TW-1:0]     r_wait_cnt;
    logic              r_cache_start;
    logic [31:0]       r_cache_addr;
    logic              r_resp0_valid;
    logic              r_resp1_valid;
    logic              r_resp_hit;
    logic              r_busy;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_hit_cnt0, r_hit_cnt1, r_miss_cnt0, r_miss_cnt1;

    logic w_idle, w_gnt0, w_gnt1, w_timeout;

    // Priority pointer only matters when both requesters are valid.
    assign w_idle    = (r_state == S_IDLE);
    assign w_gnt0    = w_idle & i_req0_valid & (~i_req1_valid | ~r_prio);
    assign w_gnt1    = w_idle & i_req1_valid & (~i_req0_valid |  r_prio);
    assign w_timeout = (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_prio        <= 1'b0;
            r_owner       <= 1'b0;
            r_hit         <= 1'b0;
            r_wait_cnt    <= '0;
            r_cache_start <= 1'b0;
            r_cache_addr  <= '0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_hit_cnt0    <= '0;
            r_hit_cnt1    <= '0;
            r_miss_cnt0   <= '0;
            r_miss_cnt1   <= '0;
        end else begin
            r_cache_start <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_hit    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_cache_addr  <= w_gnt1 ? i_req1_addr : i_req0_addr;
                        r_owner       <= w_gnt1;
                        r_cache_start <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A real done on the timeout edge still reports the cache result.
                    if (i_cache_done | w_timeout) begin
                        r_hit         <= i_cache_done & i_cache_hit;
                        r_resp_hit    <= i_cache_done & i_cache_hit;
                        r_resp0_valid <= ~r_owner;
                        r_resp1_valid <= r_owner;
                        if (!i_cache_done)
                            r_timeout_err <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                S_RESP: begin
                    if (r_owner) begin
                        if (r_hit) r_hit_cnt1  <= sat_inc(r_hit_cnt1);
                        else       r_miss_cnt1 <= sat_inc(r_miss_cnt1);
                    end else begin
                        if (r_hit) r_hit_cnt0  <= sat_inc(r_hit_cnt0);
                        else       r_miss_cnt0 <= sat_inc(r_miss_cnt0);
                    end
                    r_prio  <= ~r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req0_ready  = w_gnt0;
    assign o_req1_ready  = w_gnt1;
    assign o_resp0_valid = r_resp0_valid;
    assign o_resp1_valid = r_resp1_valid;
    assign o_resp_hit    = r_resp_hit;
    assign o_cache_start = r_cache_start;
    assign o_cache_addr  = r_cache_addr;
    assign o_hit_cnt0    = r_hit_cnt0;
    assign o_hit_cnt1    = r_hit_cnt1;
    assign o_miss_cnt0   = r_miss_cnt0;
    assign o_miss_cnt1   = r_miss_cnt1;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_l1_req_arbiter.sv
// Directed bench for l1_req_arbiter: single request, contention, timeout,
// counter saturation, reset mid-transaction and stray cache_done handling.
module tb_l1_req_arbiter;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [31:0]      req0_addr, req1_addr;
    logic             req0_ready, req1_ready;
    logic             resp0_valid, resp1_valid, resp_hit;
    logic             cache_start;
    logic [31:0]      cache_addr;
    logic             cache_done, cache_hit;
    logic [CNT_W-1:0] hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1;
    logic             busy, timeout_err;

    int total = 0;
    int bad   = 0;

    l1_req_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr),
        .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
        .o_resp0_valid(resp0_valid), .o_resp1_valid(resp1_valid),
        .o_resp_hit(resp_hit), .o_cache_start(cache_start),
        .o_cache_addr(cache_addr), .i_cache_done(cache_done),
        .i_cache_hit(cache_hit),
        .o_hit_cnt0(hit_cnt0), .o_hit_cnt1(hit_cnt1),
        .o_miss_cnt0(miss_cnt0), .o_miss_cnt1(miss_cnt1),
        .o_busy(busy), .o_timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        cache_done = 0; cache_hit = 0;
    endtask

    // Ends on a negedge with the DUT idle after one clean rising edge.
    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Minimum-latency transaction, started on a negedge in IDLE.
    task automatic do_txn(input bit who, input logic [31:0] a, input bit h);
        if (who) begin req1_valid = 1; req1_addr = a; end
        else     begin req0_valid = 1; req0_addr = a; end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        cache_done = 1; cache_hit = h;
        @(negedge clk);
        cache_done = 0; cache_hit = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        total++;
        if ({busy, cache_start, resp0_valid, resp1_valid, resp_hit, timeout_err, req0_ready, req1_ready} !== 8'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b exp 00000000",
                {busy, cache_start, resp0_valid, resp1_valid, resp_hit, timeout_err, req0_ready, req1_ready});
        end
        total++;
        if (cache_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h exp 0", cache_addr); end
        total++;
        if ({hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1} !== '0) begin
            bad++; $display("FAIL reset_cnt: got %h exp 0", {hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        req1_valid = 1; req1_addr = 32'h10;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL reset_ready: got %b exp 01", {req0_ready, req1_ready});
        end
        req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_addr = 32'h40;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL single_ready: got %b exp 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0; req0_addr = 32'hDEADBEEF;
        total++;
        if ({cache_start, busy, req0_ready} !== 3'b110) begin
            bad++; $display("FAIL single_issue: got %b exp 110", {cache_start, busy, req0_ready});
        end
        total++;
        if (cache_addr !== 32'h40) begin bad++; $display("FAIL single_addr: got %h exp 00000040", cache_addr); end
        @(negedge clk);
        total++;
        if ({cache_start, resp0_valid} !== 2'b00) begin
            bad++; $display("FAIL single_wait: got %b exp 00", {cache_start, resp0_valid});
        end
        cache_done = 1; cache_hit = 1;
        @(negedge clk);
        cache_done = 0; cache_hit = 0;
        total++;
        if ({resp0_valid, resp1_valid, resp_hit} !== 3'b101) begin
            bad++; $display("FAIL single_resp: got %b exp 101", {resp0_valid, resp1_valid, resp_hit});
        end
        @(negedge clk);
        total++;
        if ({resp0_valid, resp_hit, busy} !== 3'b000) begin
            bad++; $display("FAIL single_after: got %b exp 000", {resp0_valid, resp_hit, busy});
        end
        total++;
        if ({hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1} !== 8'b01_00_00_00) begin
            bad++; $display("FAIL single_cnt: got %b exp 01000000", {hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1});
        end
        total++;
        if (cache_addr !== 32'h40) begin bad++; $display("FAIL single_addr_hold: got %h exp 00000040", cache_addr); end
    endtask

    task automatic test_contention();
        bit          exp_own, h;
        logic [31:0] exp_addr;
        do_reset();
        req0_valid = 1; req0_addr = 32'h100;
        req1_valid = 1; req1_addr = 32'h200;
        for (int t = 0; t < 4; t++) begin
            exp_own  = t[0];
            h        = (t < 2);
            exp_addr = exp_own ? 32'h200 : 32'h100;
            #1;
            total++;
            if ({req0_ready, req1_ready} !== {~exp_own, exp_own}) begin
                bad++; $display("FAIL cont_grant%0d: got %b exp %b", t, {req0_ready, req1_ready}, {~exp_own, exp_own});
            end
            @(negedge clk);
            total++;
            if (cache_addr !== exp_addr || cache_start !== 1'b1) begin
                bad++; $display("FAIL cont_issue%0d: got %h/%b exp %h/1", t, cache_addr, cache_start, exp_addr);
            end
            @(negedge clk);
            cache_done = 1; cache_hit = h;
            @(negedge clk);
            cache_done = 0; cache_hit = 0;
            total++;
            if ({resp0_valid, resp1_valid, resp_hit} !== {~exp_own, exp_own, h}) begin
                bad++; $display("FAIL cont_resp%0d: got %b exp %b", t, {resp0_valid, resp1_valid, resp_hit}, {~exp_own, exp_own, h});
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        total++;
        if ({hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1} !== 8'b01_01_01_01) begin
            bad++; $display("FAIL cont_cnt: got %b exp 01010101", {hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1});
        end
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        req1_valid = 1; req1_addr = 32'h300;
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        early = 0;
        repeat (63) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid || !busy) early = 1;
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b exp 0", early); end
        @(negedge clk);
        total++;
        if ({resp0_valid, resp1_valid, resp_hit, timeout_err} !== 4'b0101) begin
            bad++; $display("FAIL tmo_resp: got %b exp 0101", {resp0_valid, resp1_valid, resp_hit, timeout_err});
        end
        @(negedge clk);
        total++;
        if ({miss_cnt1, hit_cnt1, busy} !== 5'b01_00_0) begin
            bad++; $display("FAIL tmo_cnt: got %b exp 01000", {miss_cnt1, hit_cnt1, busy});
        end
        do_txn(0, 32'h400, 1);
        total++;
        if ({timeout_err, hit_cnt0} !== 3'b1_01) begin
            bad++; $display("FAIL tmo_sticky: got %b exp 101", {timeout_err, hit_cnt0});
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp;
        do_reset();
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL sat_tmo_clr: got %b exp 0", timeout_err); end
        for (int n = 1; n <= 5; n++) begin
            do_txn(1, 32'h700 + n, 1);
            exp = (n < 3) ? CNT_W'(n) : 2'd3;
            total++;
            if (hit_cnt1 !== exp) begin bad++; $display("FAIL sat_hit%0d: got %0d exp %0d", n, hit_cnt1, exp); end
        end
        total++;
        if ({hit_cnt0, miss_cnt0, miss_cnt1} !== 6'b0) begin
            bad++; $display("FAIL sat_others: got %b exp 000000", {hit_cnt0, miss_cnt0, miss_cnt1});
        end
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        do_reset();
        req0_valid = 1; req0_addr = 32'h500;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rw_busy_pre: got %b exp 1", busy); end
        #2 rst_n = 0;
        #1;
        total++;
        if ({busy, resp0_valid, resp1_valid, cache_addr} !== 35'h0) begin
            bad++; $display("FAIL rw_async: got %b/%h exp 000/0", {busy, resp0_valid, resp1_valid}, cache_addr);
        end
        @(negedge clk);
        rst_n = 1;
        cache_done = 1; cache_hit = 1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid || busy) seen = 1;
        end
        cache_done = 0; cache_hit = 0;
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rw_stray: got %b exp 0", seen); end
        total++;
        if ({hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1} !== '0) begin
            bad++; $display("FAIL rw_cnt: got %h exp 0", {hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1});
        end
    endtask

    task automatic test_stray_done();
        bit seen;
        do_reset();
        cache_done = 1; cache_hit = 1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid || busy) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL stray_idle: got %b exp 0", seen); end
        req0_valid = 1; req0_addr = 32'h600;
        @(negedge clk);
        req0_valid = 0;
        total++;
        if (cache_start !== 1'b1) begin bad++; $display("FAIL stray_start: got %b exp 1", cache_start); end
        @(negedge clk);
        cache_done = 0; cache_hit = 0;
        total++;
        if ({busy, resp0_valid} !== 2'b10) begin
            bad++; $display("FAIL stray_issue: got %b exp 10", {busy, resp0_valid});
        end
        @(negedge clk);
        total++;
        if ({busy, resp0_valid} !== 2'b10) begin
            bad++; $display("FAIL stray_wait: got %b exp 10", {busy, resp0_valid});
        end
        cache_done = 1; cache_hit = 0;
        @(negedge clk);
        cache_done = 0;
        total++;
        if ({resp0_valid, resp_hit} !== 2'b10) begin
            bad++; $display("FAIL stray_resp: got %b exp 10", {resp0_valid, resp_hit});
        end
        @(negedge clk);
        total++;
        if ({miss_cnt0, hit_cnt0} !== 4'b01_00) begin
            bad++; $display("FAIL stray_cnt: got %b exp 0100", {miss_cnt0, hit_cnt0});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_saturation();
        test_reset_in_wait();
        test_stray_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
